binary_frame_pingpong: RTL and testbench
========================================

Name: binary_frame_pingpong

Overview:
- Parametrised, double-buffered (ping-pong) 1-bit image store. It sits between the binarisation/downscale preprocessor and the HDMI overlay and recogniser readers.
- The preprocessor streams a raster frame into the back bank. When the frame completes, the banks swap atomically, so readers never see a partially written frame.
- Replaces single-bank addressed-write buffering with sequential stream writes, frame commit and error reporting.

Parameters:
- IMG_W, 28, image width in pixels (2..256)
- IMG_H, 28, image height in pixels (2..256)
- CNT_W, 8, width of committed-frame counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_valid  in  1  pixel strobe
- wr_sof  in  1  first pixel of frame; qualified by wr_valid
- wr_data  in  1  pixel value
- rd_en  in  1  read request
- rd_x  in  $clog2(IMG_W)  read column
- rd_y  in  $clog2(IMG_H)  read row
- rd_data  out  1  read pixel
- rd_valid  out  1  rd_data valid strobe
- frame_ready  out  1  at least one frame committed
- frame_cnt  out  CNT_W  committed frames, wraps
- wr_err  out  1  one-cycle pulse: frame aborted or overflowed
- wr_busy  out  1  frame in progress in back bank
- ones_cnt  out  $clog2(IMG_W*IMG_H+1)  only with ONES_COUNT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, frame_ready=0, frame_cnt=0, wr_err=0, wr_busy=0, front bank=0, write pointer=0. Memory contents are not reset, so BRAM inference is preserved.
- Geometry: N = IMG_W*IMG_H. Memory is 2 banks × N bits. Linear address = y*IMG_W + x. Address width is $clog2(N) and the bank bit is the MSB.
- Write FSM states: IDLE, FILL.
  - IDLE: pixels without wr_sof are dropped silently. wr_valid&wr_sof writes the pixel to address 0 of the back bank, sets ptr=1 and enters FILL.
  - FILL: each wr_valid writes at ptr, then ptr++.
  - Commit: the pixel written at ptr=N-1 completes the frame. The next cycle toggles the front bank, increments frame_cnt, sets frame_ready=1 and returns to IDLE.
  - Abort: wr_valid&wr_sof in FILL pulses wr_err, discards the partial frame and restarts at address 0 with that pixel. No swap occurs.
- Overflow: pixels arriving in IDLE after a commit without wr_sof are dropped. If fewer than IMG_W cycles have elapsed since the commit, they also pulse wr_err once per frame.
- wr_busy = (state==FILL).
- Read latency is exactly 1 cycle: rd_valid = rd_en delayed by one cycle. rd_data is registered from the front bank.
- Read returns 0 when frame_ready=0 or when rd_x≥IMG_W or rd_y≥IMG_H.
- rd_data holds its value when rd_en=0.
- Commit and read in the same cycle: a read issued in the swap cycle uses the old front bank. The new bank is visible from the following cycle. A read of the front bank never collides with a write, because writes target only the back bank.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-FILL: the frame is abandoned, the FSM returns to IDLE and frame_ready=0.

Optional Feature:
- Macro: ONES_COUNT_EN.
- Defined: an accumulator counts pixels written with value 1 in the current fill. It clears on sof and latches into ones_cnt on the commit cycle, so it is valid in the same cycle frame_cnt increments. Aborted frames do not update ones_cnt. ones_cnt resets to 0. The recogniser uses it as a blank-digit check.
- Undefined: the ones_cnt port and the accumulator are absent.

Decomposition:
- Shared package img_pkg holds:
  - IMG_W/IMG_H defaults (28).
  - Write FSM state typedef (IDLE, FILL).
  - function xy_to_addr for use by the preprocessor and overlay.
- One sub-module: bit_dpram (1-bit simple dual-port RAM, depth 2N, registered read), instantiated once.

Test Plan:
- Reset, then rd_en at (0,0) -> rd_valid one cycle later with rd_data=0. frame_ready=0, frame_cnt=0.
- Stream 784 pixels, sof on the first, pixel=1 iff x==y -> frame_ready=1 and frame_cnt=1 two cycles after the last pixel. Read (5,5) returns 1, (5,6) returns 0, and (28,0) returns 0.
- Commit frame A (all 0), then stream frame B (all 1) while continuously reading (3,3) -> reads return 0 up to and including the swap cycle, then 1 from the next cycle.
- Send sof, 100 pixels, then a new sof -> wr_err one pulse, frame_cnt unchanged, the following full frame commits correctly.
- Run 256 full frames with CNT_W=8 -> frame_cnt wraps to 0. Assert rst mid-FILL -> wr_busy=0 and frame_ready=0 the next cycle.
- ONES_COUNT_EN with IMG_W=IMG_H=16 and 37 ones -> ones_cnt=37 at commit. An aborted frame with 5 ones leaves ones_cnt=37.

Source files
------------

// File: rtl/binary_frame_pingpong_pkg.sv
// Shared image geometry defaults, write-FSM state type and raster address helper
// for the binary frame store and its producers/consumers.
package img_pkg;

    localparam int IMG_W_DEFAULT = 28;
    localparam int IMG_H_DEFAULT = 28;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } wr_state_e;

    function automatic int unsigned xy_to_addr(input int unsigned x,
                                               input int unsigned y,
                                               input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/binary_frame_pingpong_bit_dpram.sv
// 1-bit simple dual-port RAM: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module bit_dpram
    import img_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic mem [DEPTH];
    logic rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/binary_frame_pingpong.sv
// Double-buffered 1-bit frame store: stream writes into the back bank, atomic swap on
// frame completion. Optional set-pixel count per frame under macro ONES_COUNT_EN.
//
// state | meaning
// IDLE  | waiting for sof; stray pixels dropped (overflow check shortly after a commit)
// FILL  | writing back bank at ptr; commit_q marks the swap cycle after the last pixel
module binary_frame_pingpong
    import img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_valid,
    input  logic                                   wr_sof,
    input  logic                                   wr_data,
    input  logic                                   rd_en,
    input  logic [$clog2(IMG_W)-1:0]               rd_x,
    input  logic [$clog2(IMG_H)-1:0]               rd_y,
    output logic                                   rd_data,
    output logic                                   rd_valid,
    output logic                                   frame_ready,
    output logic [CNT_W-1:0]                       frame_cnt,
    output logic                                   wr_err,
    output logic                                   wr_busy
`ifdef ONES_COUNT_EN
   ,output logic [$clog2(IMG_W*IMG_H+1)-1:0]       ones_cnt
`endif
);

    localparam int N     = IMG_W * IMG_H;
    localparam int AW    = $clog2(N);
    localparam int OVF_W = $clog2(IMG_W + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    wr_state_e         state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              commit_q, commit_d;
    logic              front_q, front_d;
    logic              frame_ready_q, frame_ready_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              wr_err_q, wr_err_d;
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic              ovf_arm_q, ovf_arm_d;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        commit_d      = 1'b0;
        front_d       = front_q;
        frame_ready_d = frame_ready_q;
        frame_cnt_d   = frame_cnt_q;
        wr_err_d      = 1'b0;
        ovf_cnt_d     = ovf_cnt_q;
        ovf_arm_d     = ovf_arm_q;
        mem_we        = 1'b0;
        mem_waddr     = '0;

        if (ovf_cnt_q != '0) begin
            ovf_cnt_d = ovf_cnt_q - OVF_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_valid && wr_sof) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    ptr_d     = AW'(1);
                    ovf_arm_d = 1'b0;
                    state_d   = ST_FILL;
                end else if (wr_valid && ovf_arm_q && (ovf_cnt_q != '0)) begin
                    wr_err_d  = 1'b1;
                    ovf_arm_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (commit_q) begin
                    front_d       = ~front_q;
                    frame_cnt_d   = frame_cnt_q + CNT_W'(1);
                    frame_ready_d = 1'b1;
                    ptr_d         = '0;
                    ovf_cnt_d     = OVF_W'(IMG_W);
                    ovf_arm_d     = 1'b1;
                    state_d       = ST_IDLE;
                    // Nothing may be written during the swap; any pixel here is lost.
                    if (wr_valid) begin
                        wr_err_d  = 1'b1;
                        ovf_arm_d = 1'b0;
                    end
                end else if (wr_valid && wr_sof) begin
                    wr_err_d  = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    ptr_d     = AW'(1);
                end else if (wr_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    ptr_d     = ptr_q + AW'(1);
                    commit_d  = (ptr_q == LAST_ADDR);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            commit_q      <= 1'b0;
            front_q       <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            wr_err_q      <= 1'b0;
            ovf_cnt_q     <= '0;
            ovf_arm_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            commit_q      <= commit_d;
            front_q       <= front_d;
            frame_ready_q <= frame_ready_d;
            frame_cnt_q   <= frame_cnt_d;
            wr_err_q      <= wr_err_d;
            ovf_cnt_q     <= ovf_cnt_d;
            ovf_arm_q     <= ovf_arm_d;
        end
    end

    // Read side: RAM output register holds between reads; zero mask is tracked alongside.
    logic          rd_in_range;
    logic [AW-1:0] rd_lin;
    logic          rd_zero_q;
    logic          rd_valid_q;
    logic          ram_dout;

    assign rd_in_range = (32'(rd_x) < 32'(IMG_W)) && (32'(rd_y) < 32'(IMG_H));
    assign rd_lin      = AW'(xy_to_addr(32'(rd_x), 32'(rd_y), 32'(IMG_W)));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_zero_q  <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_zero_q <= ~frame_ready_q | ~rd_in_range;
            end
        end
    end

    bit_dpram #(
        .ADDR_W (AW + 1)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (mem_we),
        .wr_addr_i ({~front_q, mem_waddr}),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i ({front_q, rd_lin}),
        .rd_data_o (ram_dout)
    );

`ifdef ONES_COUNT_EN
    localparam int OW = $clog2(N + 1);

    logic [OW-1:0] ones_acc_q, ones_acc_d;
    logic [OW-1:0] ones_cnt_q, ones_cnt_d;

    always_comb begin
        ones_acc_d = ones_acc_q;
        ones_cnt_d = ones_cnt_q;
        // Address 0 is only ever written by an sof pixel, so it restarts the count.
        if (mem_we) begin
            ones_acc_d = (mem_waddr == '0) ? OW'(wr_data) : ones_acc_q + OW'(wr_data);
        end
        if (commit_q) begin
            ones_cnt_d = ones_acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_acc_q <= '0;
            ones_cnt_q <= '0;
        end else begin
            ones_acc_q <= ones_acc_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign ones_cnt = ones_cnt_q;
`endif

    assign rd_data     = ram_dout & ~rd_zero_q;
    assign rd_valid    = rd_valid_q;
    assign frame_ready = frame_ready_q;
    assign frame_cnt   = frame_cnt_q;
    assign wr_err      = wr_err_q;
    assign wr_busy     = (state_q == ST_FILL);

endmodule

// File: tb/tb_binary_frame_pingpong.sv
// Self-checking bench for binary_frame_pingpong: a 28x28 instance for the main checks
// and a 2x2 instance for the frame counter wrap.
module tb_binary_frame_pingpong;

    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       wr_valid = 1'b0, wr_sof = 1'b0, wr_data = 1'b0, rd_en = 1'b0;
    logic [4:0] rd_x = '0, rd_y = '0;
    logic       rd_data, rd_valid, frame_ready, wr_err, wr_busy;
    logic [7:0] frame_cnt;

    logic       w_valid = 1'b0, w_sof = 1'b0, w_data = 1'b0;
    logic       s_rd_data, s_rd_valid, s_ready, s_err, s_busy;
    logic [7:0] s_cnt;

`ifdef ONES_COUNT_EN
    logic [9:0] ones_cnt;
    logic [2:0] s_ones;
`endif

    binary_frame_pingpong #(.IMG_W(W), .IMG_H(H), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .frame_cnt(frame_cnt), .wr_err(wr_err), .wr_busy(wr_busy)
`ifdef ONES_COUNT_EN
       ,.ones_cnt(ones_cnt)
`endif
    );

    binary_frame_pingpong #(.IMG_W(2), .IMG_H(2), .CNT_W(8)) dut_small (
        .clk(clk), .rst(rst), .wr_valid(w_valid), .wr_sof(w_sof), .wr_data(w_data),
        .rd_en(1'b0), .rd_x(1'b0), .rd_y(1'b0), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .frame_ready(s_ready), .frame_cnt(s_cnt), .wr_err(s_err), .wr_busy(s_busy)
`ifdef ONES_COUNT_EN
       ,.ones_cnt(s_ones)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic exp;
        int   cyc;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int   x;
        int   y;
        logic exp;
    } rd_vec_t;
    rd_vec_t rtab[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read scoreboard: each read must come back exactly one cycle after issue.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc + 1 < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_valid_missing: read issued at cycle %0d never returned", sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (rd_valid) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_spurious: rd_valid with no read outstanding (cycle %0d)", cyc);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.cyc + 1 != cyc || rd_data !== e.exp) begin
                    n_err++;
                    $display("FAIL rd_data: got %0b at cycle %0d expected %0b at cycle %0d",
                             rd_data, cyc, e.exp, e.cyc + 1);
                end
            end
        end
    end

    task automatic step(input logic v, input logic s, input logic d,
                        input logic re, input int x, input int y, input logic ex);
        sb_t e;
        @(negedge clk);
        wr_valid = v; wr_sof = s; wr_data = d;
        rd_en = re; rd_x = x[4:0]; rd_y = y[4:0];
        w_valid = 1'b0; w_sof = 1'b0; w_data = 1'b0;
        if (re) begin
            e.exp = ex;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic step0();
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wstep(input logic v, input logic s, input logic d);
        @(negedge clk);
        wr_valid = 1'b0; wr_sof = 1'b0; wr_data = 1'b0; rd_en = 1'b0;
        w_valid = v; w_sof = s; w_data = d;
    endtask

    function automatic logic pix(input int pat, input int x, input int y);
        case (pat)
            0:       return (x == y);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ((x + 2 * y) % 3 == 0);
        endcase
    endfunction

    function automatic int count_ones(input int pat);
        int c = 0;
        for (int p = 0; p < N; p++) c += int'(pix(pat, p % W, p / W));
        return c;
    endfunction

    // Streams a full frame; with abort_chk, the sof is expected to abort a partial frame
    // holding cnt_before commits.
    task automatic send_frame(input int pat, input bit abort_chk, input int cnt_before);
        for (int p = 0; p < N; p++) begin
            step(1'b1, p == 0, pix(pat, p % W, p / W), 1'b0, 0, 0, 1'b0);
            if (p == 2) chk("busy_fill", wr_busy, 1);
            if (abort_chk && p == 1) chk("abort_err", wr_err, 1);
            if (abort_chk && p == 2) chk("abort_err_pulse", wr_err, 0);
            if (abort_chk && p == 3) chk("abort_cnt", frame_cnt, cnt_before);
        end
    endtask

    initial begin
        rtab[0] = '{5, 5, 1'b1};
        rtab[1] = '{5, 6, 1'b0};
        rtab[2] = '{28, 0, 1'b0};
        rtab[3] = '{0, 0, 1'b1};
        rtab[4] = '{27, 27, 1'b1};
        rtab[5] = '{27, 0, 1'b0};
        rtab[6] = '{0, 31, 1'b0};
        rtab[7] = '{31, 31, 1'b0};
        rtab[8] = '{10, 11, 1'b0};
        rtab[9] = '{13, 13, 1'b1};

        rst = 1'b1;
        repeat (3) step0();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_frame_ready", frame_ready, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_wr_busy", wr_busy, 0);
        rst = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        step0();
        step0();
        chk("empty_ready", frame_ready, 0);

        // Diagonal frame: visible two cycles after the last pixel.
        send_frame(0, 1'b0, 0);
        step0();
        chk("diag_busy_last", wr_busy, 1);
        chk("diag_ready_early", frame_ready, 0);
        step0();
        chk("diag_ready", frame_ready, 1);
        chk("diag_cnt", frame_cnt, 1);
        chk("diag_busy_done", wr_busy, 0);
`ifdef ONES_COUNT_EN
        chk("diag_ones", ones_cnt, count_ones(0));
`endif

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, rtab[i].x, rtab[i].y, rtab[i].exp);
        end
        step0();
        step0();
        chk("rd_hold_data", rd_data, 1);
        chk("rd_hold_valid", rd_valid, 0);

        // Stray pixels shortly after the commit: one error pulse only.
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("ovf_err", wr_err, 1);
        step0();
        chk("ovf_err_once", wr_err, 0);
        chk("ovf_cnt", frame_cnt, 1);
        chk("ovf_busy", wr_busy, 0);

        send_frame(1, 1'b0, 0);
        step0();
        step0();
        chk("frameA_cnt", frame_cnt, 2);

        // Frame B (all ones) with a read of (3,3) every cycle: new bank only after the swap.
        for (int i = 0; i < N + 4; i++) begin
            step(i < N, i == 0, 1'b1, 1'b1, 3, 3, i >= N + 1);
        end
        step0();
        step0();
        chk("frameB_cnt", frame_cnt, 3);
`ifdef ONES_COUNT_EN
        chk("frameB_ones", ones_cnt, N);
`endif

        // 100-pixel partial frame aborted by a fresh sof, then a full frame.
        for (int p = 0; p < 100; p++) begin
            step(1'b1, p == 0, 1'b1, 1'b0, 0, 0, 1'b0);
        end
        send_frame(3, 1'b1, 3);
`ifdef ONES_COUNT_EN
        chk("abort_ones_kept", ones_cnt, N);
`endif
        step0();
        step0();
        chk("after_abort_cnt", frame_cnt, 4);
        chk("after_abort_err", wr_err, 0);
`ifdef ONES_COUNT_EN
        chk("pat3_ones", ones_cnt, count_ones(3));
`endif
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, (k * 5) % W, (k * 7 + 1) % H,
                 pix(3, (k * 5) % W, (k * 7 + 1) % H));
        end
        step0();
        step0();

        // Reset in the middle of a fill.
        for (int p = 0; p < 50; p++) begin
            step(1'b1, p == 0, 1'b1, 1'b0, 0, 0, 1'b0);
        end
        rst = 1'b1;
        step0();
        chk("midrst_busy", wr_busy, 0);
        chk("midrst_ready", frame_ready, 0);
        chk("midrst_cnt", frame_cnt, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0);
        step0();
        step0();

        // Counter wrap on the 2x2 instance: 256 commits bring frame_cnt back to 0.
        for (int f = 0; f < 256; f++) begin
            wstep(1'b1, 1'b1, 1'b0);
            if (f == 255) chk("wrap_cnt_255", s_cnt, 255);
            wstep(1'b1, 1'b0, 1'b1);
            wstep(1'b1, 1'b0, 1'b0);
            wstep(1'b1, 1'b0, 1'b1);
            wstep(1'b0, 1'b0, 1'b0);
        end
        wstep(1'b0, 1'b0, 1'b0);
        chk("wrap_cnt_0", s_cnt, 0);
        chk("wrap_ready", s_ready, 1);
        chk("wrap_err", s_err, 0);
`ifdef ONES_COUNT_EN
        chk("wrap_ones", s_ones, 2);
`endif

        repeat (3) step0();
        chk("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL timeout: bench did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

endmodule
